// File: rtl/mdu_seq_ctrl.sv
// Iterative unsigned multiply/divide sequencer that sits beside the ALU in execute.
// busy stalls the pipeline while it iterates; Result/Remainder/ALUFlags update on entering DONE.
module mdu_seq_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BPC   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] Remainder,
   output logic [3:0]       ALUFlags
);

   localparam int unsigned N       = WIDTH / BPC;
   localparam logic [5:0]  LastCnt = 6'(N - 1);
   localparam logic [2:0]  OpMul   = 3'b100;
   localparam logic [2:0]  OpDiv   = 3'b101;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q;
   logic [5:0]           cnt_q;
   logic                 is_div_q;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     divisor_q;
   logic [WIDTH:0]       trial;
   logic [WIDTH-1:0]     res_fin;

   // BPC unrolled steps per cycle; quo shifts the dividend out MSB-first and quotient bits in.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      trial    = '0;
      for (int unsigned i = 0; i < BPC; i++) begin
         if (is_div_q) begin
            trial = {rem_d, quo_d[WIDTH-1]};
            if (trial >= {1'b0, divisor_q}) begin
               rem_d = trial[WIDTH-1:0] - divisor_q;
               quo_d = {quo_d[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_d[WIDTH-2:0], 1'b0};
            end
         end else begin
            if (mplier_d[0]) begin
               acc_d = acc_d + mcand_d;
            end
            mcand_d  = mcand_d << 1;
            mplier_d = mplier_d >> 1;
         end
      end
      res_fin = is_div_q ? quo_d : acc_d[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         Result    <= '0;
         Remainder <= '0;
         ALUFlags  <= 4'b0000;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start && (op == OpMul || op == OpDiv)) begin
                  is_div_q  <= (op == OpDiv);
                  acc_q     <= '0;
                  mcand_q   <= {{WIDTH{1'b0}}, A};
                  mplier_q  <= B;
                  rem_q     <= '0;
                  quo_q     <= A;
                  divisor_q <= B;
                  cnt_q     <= '0;
                  busy      <= 1'b1;
                  if (op == OpDiv && B == '0) begin
                     state_q   <= StDone;
                     done      <= 1'b1;
                     Result    <= '0;
                     Remainder <= '0;
                     ALUFlags  <= 4'b0100;
                  end else begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_d;
               mplier_q <= mplier_d;
               rem_q    <= rem_d;
               quo_q    <= quo_d;
               cnt_q    <= cnt_q + 6'd1;
               if (cnt_q == LastCnt) begin
                  state_q   <= StDone;
                  done      <= 1'b1;
                  Result    <= res_fin;
                  Remainder <= is_div_q ? rem_d : '0;
                  ALUFlags  <= {res_fin[WIDTH-1], res_fin == '0, 2'b00};
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Bench for mdu_seq_ctrl: BPC=1 and BPC=4 instances driven in lockstep,
// checked against arithmetic expectations for latency, pulse shape and results.
module tb_mdu_seq_ctrl;

   localparam logic [2:0] OpMul = 3'b100;
   localparam logic [2:0] OpDiv = 3'b101;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        busy1, done1, busy4, done4;
   logic [31:0] res1, rem1, res4, rem4;
   logic [3:0]  flg1, flg4;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_res, last_rem;
   logic [3:0]  last_flg;

   mdu_seq_ctrl #(.WIDTH(32), .BPC(1)) u1 (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .busy(busy1), .done(done1), .Result(res1), .Remainder(rem1), .ALUFlags(flg1)
   );

   mdu_seq_ctrl #(.WIDTH(32), .BPC(4)) u4 (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .busy(busy4), .done(done4), .Result(res4), .Remainder(rem4), .ALUFlags(flg4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] rem;
      logic [3:0]  flags;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Issues one op, watches a fixed 35-edge window, then checks both instances.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [31:0] erem,
                         input logic [3:0] ef, input bit poke);
      int lat1, lat4, nd1, nd4, nb1, nb4, el1, el4;
      bit dz;
      lat1 = 0; lat4 = 0; nd1 = 0; nd4 = 0; nb1 = 0; nb4 = 0;
      dz  = (o == OpDiv) && (b == 32'd0);
      el1 = dz ? 1 : 33;
      el4 = dz ? 1 : 9;
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'b000; A = $urandom; B = $urandom;
      for (int e = 1; e <= 35; e++) begin
         if (done1) begin nd1++; if (lat1 == 0) lat1 = e; end
         if (done4) begin nd4++; if (lat4 == 0) lat4 = e; end
         if (busy1) nb1++;
         if (busy4) nb4++;
         if (poke && (e == 3 || e == 5)) begin
            @(negedge clk);
            start = 1'b1; op = OpMul; A = 32'd9; B = 32'd9;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("lat_bpc1", lat1, el1);
      chk("lat_bpc4", lat4, el4);
      chk("done_pulses_bpc1", nd1, 1);
      chk("done_pulses_bpc4", nd4, 1);
      chk("busy_cycles_bpc1", nb1, el1);
      chk("busy_cycles_bpc4", nb4, el4);
      chk("idle_after_bpc1", busy1, 0);
      chk("idle_after_bpc4", busy4, 0);
      chk("result_bpc1", res1, er);
      chk("result_bpc4", res4, er);
      chk("remainder_bpc1", rem1, erem);
      chk("remainder_bpc4", rem4, erem);
      chk("flags_bpc1", flg1, ef);
      chk("flags_bpc4", flg4, ef);
      last_res = er; last_rem = erem; last_flg = ef;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy1"}, busy1, 0);
      chk({tag, "_done1"}, done1, 0);
      chk({tag, "_res1"}, res1, 0);
      chk({tag, "_rem1"}, rem1, 0);
      chk({tag, "_flg1"}, flg1, 0);
      chk({tag, "_busy4"}, busy4, 0);
      chk({tag, "_res4"}, res4, 0);
      chk({tag, "_flg4"}, flg4, 0);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb, rres, rrem;
      logic [63:0] prod;

      tbl[0] = '{OpMul, 32'd7,          32'd6,     32'd42,         32'd0, 4'b0000};
      tbl[1] = '{OpDiv, 32'd100,        32'd7,     32'd14,         32'd2, 4'b0000};
      tbl[2] = '{OpDiv, 32'd5,          32'd0,     32'd0,          32'd0, 4'b0100};
      tbl[3] = '{OpMul, 32'hFFFF_FFFF,  32'd2,     32'hFFFF_FFFE,  32'd0, 4'b1000};
      tbl[4] = '{OpDiv, 32'd0,          32'd3,     32'd0,          32'd0, 4'b0100};
      tbl[5] = '{OpDiv, 32'hFFFF_FFFF,  32'd1,     32'hFFFF_FFFF,  32'd0, 4'b1000};
      tbl[6] = '{OpMul, 32'd0,          32'd12345, 32'd0,          32'd0, 4'b0100};
      tbl[7] = '{OpDiv, 32'd6,          32'd7,     32'd0,          32'd6, 4'b0100};
      tbl[8] = '{OpMul, 32'd10000,      32'd10000, 32'h05F5_E100,  32'd0, 4'b0000};
      tbl[9] = '{OpDiv, 32'h8000_0000,  32'd3,     32'h2AAA_AAAA,  32'd2, 4'b0000};

      reset = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0;
      last_res = '0; last_rem = '0; last_flg = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_busy", busy1, 0);

      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].rem, tbl[i].flags, 1'b0);
      end

      // Unsupported op codes while idle: no busy, outputs keep the last result.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         start = 1'b1; op = (k == 0) ? 3'b000 : 3'b110; A = 32'd1; B = 32'd1;
         @(posedge clk); #1;
         start = 1'b0;
         for (int c = 0; c < 4; c++) begin
            chk("illegal_busy1", busy1, 0);
            chk("illegal_busy4", busy4, 0);
            chk("illegal_done1", done1, 0);
            @(posedge clk); #1;
         end
         chk("illegal_hold_res1", res1, last_res);
         chk("illegal_hold_rem1", rem1, last_rem);
         chk("illegal_hold_flg4", flg4, last_flg);
         chk("illegal_hold_res4", res4, last_res);
      end

      // start pulses while running must be ignored
      run_op(OpMul, 32'd1000, 32'd3, 32'd3000, 32'd0, 4'b0000, 1'b1);
      run_op(OpDiv, 32'd77, 32'd10, 32'd7, 32'd7, 4'b0000, 1'b1);

      for (int r = 0; r < 30; r++) begin
         ro = ($urandom_range(1, 0) == 1) ? OpDiv : OpMul;
         ra = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(255, 0)) : $urandom;
         rb = ($urandom_range(7, 0) == 0) ? 32'd0 :
              ($urandom_range(2, 0) == 0) ? 32'($urandom_range(300, 1)) : $urandom;
         if (ro == OpMul) begin
            prod = {32'd0, ra} * {32'd0, rb};
            rres = prod[31:0];
            rrem = 32'd0;
         end else if (rb == 32'd0) begin
            rres = 32'd0;
            rrem = 32'd0;
         end else begin
            rres = ra / rb;
            rrem = ra % rb;
         end
         run_op(ro, ra, rb, rres, rrem, {rres[31], rres == 32'd0, 2'b00}, 1'b0);
      end

      // Asynchronous reset in the middle of a BPC=1 multiply.
      @(negedge clk);
      start = 1'b1; op = OpMul; A = 32'd123; B = 32'd456;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("midop_busy1", busy1, 1);
      reset = 1'b1;
      #1;
      check_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      last_res = '0; last_rem = '0; last_flg = '0;
      run_op(OpMul, 32'd3, 32'd5, 32'd15, 32'd0, 4'b0000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
